inert_serf: RTL and testbench

SPI responder modelling the inertial sensor at the far end of the inertial interface. It decodes 16-bit SPI transactions from the inertial-interface master and serves a small register file: identity, control, interrupt enable, and pitch/roll/yaw data. It latches new samples from its `*_src` inputs at a programmable rate and raises `INT` when a new sample is ready. It sits in test harnesses and FPGA loopback builds in place of the physical sensor.

---
 rtl/inert_serf.sv | 260 ++++++++++++++++++++++++++
 tb/tb_inert_serf.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inert_serf.sv
// SPI responder standing in for the inertial sensor: 16-bit frames, small register file,
// periodic sampling of pitch/roll/yaw with a level data-ready interrupt.
module inert_serf #(
   parameter int         SAMPLE_PERIOD = 50000,
   parameter logic [7:0] WHO_AM_I_VAL  = 8'h6A
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_src,
   input  logic [15:0] roll_src,
   input  logic [15:0] yaw_src
);

   // state  | meaning
   // IDLE   | no frame; free ticks latch samples directly
   // ADDR   | counting the first 8 SCLK rises (R/W + address)
   // DATA   | shifting read data out on SCLK falls
   // COMMIT | one cycle: apply write / INT clear / pending sample
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ADDR   = 2'd1,
      S_DATA   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   localparam logic [6:0]  A_INT1   = 7'h0D;
   localparam logic [6:0]  A_WHO    = 7'h0F;
   localparam logic [6:0]  A_CTRL1  = 7'h10;
   localparam logic [6:0]  A_CTRL2  = 7'h11;
   localparam logic [6:0]  A_PTCH_L = 7'h22;
   localparam logic [6:0]  A_PTCH_H = 7'h23;
   localparam logic [6:0]  A_ROLL_L = 7'h24;
   localparam logic [6:0]  A_ROLL_H = 7'h25;
   localparam logic [6:0]  A_YAW_L  = 7'h26;
   localparam logic [6:0]  A_YAW_H  = 7'h27;
   localparam logic [15:0] SMP_LAST = 16'(SAMPLE_PERIOD - 1);

   logic ss_s1_q, ss_s2_q, ss_d3_q;
   logic sclk_s1_q, sclk_s2_q, sclk_d3_q;
   logic mosi_s1_q, mosi_s2_q, mosi_d3_q;
   logic [1:0] fill_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_s1_q   <= 1'b1;
         ss_s2_q   <= 1'b1;
         ss_d3_q   <= 1'b1;
         sclk_s1_q <= 1'b1;
         sclk_s2_q <= 1'b1;
         sclk_d3_q <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         mosi_d3_q <= 1'b0;
         fill_q    <= 2'd0;
      end else begin
         ss_s1_q   <= SS_n;
         ss_s2_q   <= ss_s1_q;
         ss_d3_q   <= ss_s2_q;
         sclk_s1_q <= SCLK;
         sclk_s2_q <= sclk_s1_q;
         sclk_d3_q <= sclk_s2_q;
         mosi_s1_q <= MOSI;
         mosi_s2_q <= mosi_s1_q;
         mosi_d3_q <= mosi_s2_q;
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      end
   end

   // A select already low at reset release only looks like a fall until the
   // synchroniser has filled from the pin; ignore it so that frame is skipped.
   logic ss_fall, ss_rise, sclk_rise, sclk_fall;
   assign ss_fall   = (fill_q == 2'd3) & ss_d3_q & ~ss_s2_q;
   assign ss_rise   = ss_s2_q & ~ss_d3_q;
   assign sclk_rise = sclk_s2_q & ~sclk_d3_q;
   assign sclk_fall = ~sclk_s2_q & sclk_d3_q;

   state_t state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] shift_q, shift_d;
   logic        rw_q, rw_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic [7:0]  int1_q, int1_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d;
   logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
   logic [15:0] smp_q, smp_d;
   logic        int_q, int_d, pend_q, pend_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (ss_fall) state_d = S_ADDR;
         S_ADDR: begin
            if (ss_rise)                              state_d = S_IDLE;
            else if (sclk_rise && cnt_q == 5'd7)      state_d = S_DATA;
         end
         S_DATA:   if (ss_rise) state_d = (cnt_q == 5'd16) ? S_COMMIT : S_IDLE;
         S_COMMIT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   logic frame_start, snap, shift_en, tx_shift, do_commit, in_idle;
   always_comb begin
      frame_start = 1'b0;
      snap        = 1'b0;
      shift_en    = 1'b0;
      tx_shift    = 1'b0;
      do_commit   = 1'b0;
      in_idle     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_idle     = 1'b1;
            frame_start = ss_fall;
         end
         S_ADDR: begin
            shift_en = sclk_rise;
            snap     = sclk_rise && (cnt_q == 5'd7);
         end
         S_DATA: begin
            shift_en = sclk_rise;
            tx_shift = sclk_fall;
         end
         S_COMMIT: do_commit = 1'b1;
         default: ;
      endcase
   end

   // At the 8th rise the address is the 6 bits already shifted plus the bit arriving now.
   logic [6:0] rd_addr;
   logic [7:0] rd_data;
   assign rd_addr = {shift_q[5:0], mosi_d3_q};

   always_comb begin
      rd_data = 8'h00;
      unique case (rd_addr)
         A_INT1:   rd_data = int1_q;
         A_WHO:    rd_data = WHO_AM_I_VAL;
         A_CTRL1:  rd_data = ctrl1_q;
         A_CTRL2:  rd_data = ctrl2_q;
         A_PTCH_L: rd_data = ptch_q[7:0];
         A_PTCH_H: rd_data = ptch_q[15:8];
         A_ROLL_L: rd_data = roll_q[7:0];
         A_ROLL_H: rd_data = roll_q[15:8];
         A_YAW_L:  rd_data = yaw_q[7:0];
         A_YAW_H:  rd_data = yaw_q[15:8];
         default:  rd_data = 8'h00;
      endcase
   end

   logic       tick, apply, wr_en, int_clr;
   logic [6:0] wr_addr;
   assign tick    = int1_q[1] && (smp_q == SMP_LAST);
   assign apply   = (in_idle | do_commit) & (tick | pend_q);
   assign wr_addr = shift_q[14:8];
   assign wr_en   = do_commit & ~shift_q[15];
   assign int_clr = do_commit & shift_q[15] & (wr_addr == A_YAW_H);

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      rw_d    = rw_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      int1_d  = int1_q;
      ctrl1_d = ctrl1_q;
      ctrl2_d = ctrl2_q;
      ptch_d  = ptch_q;
      roll_d  = roll_q;
      yaw_d   = yaw_q;
      smp_d   = smp_q;
      int_d   = int_q;
      pend_d  = pend_q;

      if (frame_start)                        cnt_d = 5'd0;
      else if (shift_en && cnt_q != 5'd31)    cnt_d = cnt_q + 5'd1;
      if (shift_en) shift_d = {shift_q[14:0], mosi_d3_q};

      if (snap) begin
         rw_d = shift_q[6];
         tx_d = rd_data;
      end else if (tx_shift) begin
         tx_d = {tx_q[6:0], 1'b0};
      end
      if (state_q != S_DATA) miso_d = 1'b0;
      else if (tx_shift)     miso_d = rw_q & tx_q[7];

      if (wr_en) begin
         unique case (wr_addr)
            A_INT1:  int1_d  = shift_q[7:0];
            A_CTRL1: ctrl1_d = shift_q[7:0];
            A_CTRL2: ctrl2_d = shift_q[7:0];
            default: ;
         endcase
      end

      if (!int1_q[1]) smp_d = 16'd0;
      else if (tick)  smp_d = 16'd0;
      else            smp_d = smp_q + 16'd1;

      if (apply) begin
         ptch_d = ptch_src;
         roll_d = roll_src;
         yaw_d  = yaw_src;
         pend_d = 1'b0;
      end else if (tick) begin
         pend_d = 1'b1;
      end

      if (apply)        int_d = 1'b1;
      else if (int_clr) int_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= 5'd0;
         shift_q <= 16'd0;
         rw_q    <= 1'b0;
         tx_q    <= 8'd0;
         miso_q  <= 1'b0;
         int1_q  <= 8'd0;
         ctrl1_q <= 8'd0;
         ctrl2_q <= 8'd0;
         ptch_q  <= 16'd0;
         roll_q  <= 16'd0;
         yaw_q   <= 16'd0;
         smp_q   <= 16'd0;
         int_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         rw_q    <= rw_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
         int1_q  <= int1_d;
         ctrl1_q <= ctrl1_d;
         ctrl2_q <= ctrl2_d;
         ptch_q  <= ptch_d;
         roll_q  <= roll_d;
         yaw_q   <= yaw_d;
         smp_q   <= smp_d;
         int_q   <= int_d;
         pend_q  <= pend_d;
      end
   end

   assign MISO = miso_q;
   assign INT  = int_q;

endmodule

// File: tb/tb_inert_serf.sv
// Bench for inert_serf: directed SPI frames plus randomized sample/register traffic
// checked against a register-level model of the sensor.
module tb_inert_serf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b0;
   logic        MOSI = 1'b0;
   logic        MISO, INT;
   logic [15:0] ptch_src = 16'h1234;
   logic [15:0] roll_src = 16'h0001;
   logic [15:0] yaw_src  = 16'hFF80;

   int total = 0;
   int bad   = 0;

   inert_serf #(.SAMPLE_PERIOD(100), .WHO_AM_I_VAL(8'h6A)) dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .MISO(MISO), .INT(INT),
      .ptch_src(ptch_src), .roll_src(roll_src), .yaw_src(yaw_src)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: summary not reached, time=%0t limit=600000", $time);
      $fatal(1, "watchdog expired");
   end

   // Sensor model: register contents as the master should see them.
   logic [7:0]  m_int1, m_ctrl1, m_ctrl2;
   logic [15:0] m_p, m_r, m_y;

   function automatic logic [7:0] mdl(input logic [6:0] a);
      case (a)
         7'h0D:   return m_int1;
         7'h0F:   return 8'h6A;
         7'h10:   return m_ctrl1;
         7'h11:   return m_ctrl2;
         7'h22:   return m_p[7:0];
         7'h23:   return m_p[15:8];
         7'h24:   return m_r[7:0];
         7'h25:   return m_r[15:8];
         7'h26:   return m_y[7:0];
         7'h27:   return m_y[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Mode-0 master at clk/32; sources switch to np/nr/ny after the 5th rise.
   task automatic xfer(input logic [15:0] w, input int nrise, input logic raise_ss,
                       input logic [15:0] np, input logic [15:0] nr, input logic [15:0] ny,
                       output logic [7:0] rd);
      rd = 8'h00;
      repeat (8) @(negedge clk);
      SS_n = 1'b0;
      MOSI = w[15];
      repeat (16) @(negedge clk);
      for (int i = 0; i < nrise; i++) begin
         if (i >= 8) rd[15-i] = MISO;
         SCLK = 1'b1;
         if (i == 4) begin
            ptch_src = np;
            roll_src = nr;
            yaw_src  = ny;
         end
         repeat (16) @(negedge clk);
         SCLK = 1'b0;
         if (i < 15) MOSI = w[14-i];
         repeat (16) @(negedge clk);
      end
      if (raise_ss) begin
         SS_n = 1'b1;
         MOSI = 1'b0;
      end
   endtask

   task automatic rd_chg(input string tag, input logic [6:0] a, input logic [7:0] exp,
                         input logic [15:0] np, input logic [15:0] nr, input logic [15:0] ny);
      logic [7:0] rd;
      xfer({1'b1, a, 8'h00}, 16, 1'b1, np, nr, ny, rd);
      check(tag, {24'd0, rd}, {24'd0, exp});
   endtask

   task automatic rd_reg(input string tag, input logic [6:0] a, input logic [7:0] exp);
      rd_chg(tag, a, exp, ptch_src, roll_src, yaw_src);
   endtask

   task automatic wr_reg(input string tag, input logic [6:0] a, input logic [7:0] d);
      logic [7:0] rd;
      xfer({1'b0, a, d}, 16, 1'b1, ptch_src, roll_src, yaw_src, rd);
      check(tag, {24'd0, rd}, 32'd0);
   endtask

   int          lat, kind;
   logic [6:0]  a;
   logic [7:0]  d, e, junk;
   logic [15:0] np, nr, ny;

   initial begin
      m_int1 = 8'h00; m_ctrl1 = 8'h00; m_ctrl2 = 8'h00;
      m_p = 16'h0; m_r = 16'h0; m_y = 16'h0;

      repeat (3) @(negedge clk);
      check("reset_miso", {31'd0, MISO}, 32'd0);
      check("reset_int", {31'd0, INT}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      rd_reg("who_am_i", 7'h0F, 8'h6A);
      check("int_after_who", {31'd0, INT}, 32'd0);
      rd_reg("ctrl1_reset", 7'h10, 8'h00);
      rd_reg("unmapped_read", 7'h00, 8'h00);
      rd_reg("pitch_lo_reset", 7'h22, 8'h00);

      // Enable ticks and time the first data-ready edge from the SS_n rise.
      wr_reg("wr_int1_miso", 7'h0D, 8'h02);
      m_int1 = 8'h02;
      lat = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (INT === 1'b1) begin
            lat = k;
            break;
         end
      end
      check("first_tick_latency", lat, 104);
      m_p = ptch_src; m_r = roll_src; m_y = yaw_src;
      rd_reg("int1_readback", 7'h0D, 8'h02);
      rd_reg("pitch_lo", 7'h22, 8'h34);
      rd_reg("pitch_hi", 7'h23, 8'h12);
      check("int_set", {31'd0, INT}, 32'd1);

      // Tick inside a frame: the frame sees old roll, the commit latches new.
      rd_chg("roll_in_frame_old", 7'h24, 8'h01, ptch_src, 16'h0202, yaw_src);
      m_r = 16'h0202;
      rd_reg("roll_after_frame", 7'h24, 8'h02);
      check("int_after_pending", {31'd0, INT}, 32'd1);

      for (int it = 0; it < 8; it++) begin
         kind = int'($urandom_range(0, 3));
         if (kind <= 1) begin
            a  = 7'(7'h22 + $urandom_range(0, 5));
            np = 16'($urandom); nr = 16'($urandom); ny = 16'($urandom);
            rd_chg("rand_data_read", a, mdl(a), np, nr, ny);
            m_p = np; m_r = nr; m_y = ny;
            if (a == 7'h27) begin
               repeat (4) @(negedge clk);
               check("rand_clear_vs_set", {31'd0, INT}, 32'd1);
            end
         end else if (kind == 2) begin
            d = 8'($urandom);
            wr_reg("rand_wr_ctrl2_miso", 7'h11, d);
            m_ctrl2 = d;
            rd_reg("rand_ctrl2", 7'h11, mdl(7'h11));
         end else begin
            a = ($urandom_range(0, 1) == 0) ? 7'h0F : 7'h23;
            d = 8'($urandom);
            wr_reg("rand_wr_ro_miso", a, d);
            rd_reg("rand_ro_unchanged", a, mdl(a));
         end
      end
      check("int_after_random", {31'd0, INT}, 32'd1);

      // Short frame must not write; the full frame must.
      xfer(16'h1055, 12, 1'b1, ptch_src, roll_src, yaw_src, junk);
      rd_reg("ctrl1_after_abort", 7'h10, 8'h00);
      wr_reg("wr_ctrl1_miso", 7'h10, 8'h55);
      m_ctrl1 = 8'h55;
      rd_reg("ctrl1_full_write", 7'h10, 8'h55);

      // Disable ticks; the disabling frame still latches its pending sample.
      yaw_src = 16'hFF80;
      wr_reg("wr_disable_miso", 7'h0D, 8'h00);
      m_int1 = 8'h00;
      m_p = ptch_src; m_r = roll_src; m_y = yaw_src;
      repeat (20) @(negedge clk);
      rd_reg("yaw_lo", 7'h26, 8'h80);
      repeat (4) @(negedge clk);
      check("int_kept_by_a6", {31'd0, INT}, 32'd1);
      e = mdl(7'h27);
      rd_reg("yaw_hi", 7'h27, e);
      repeat (3) @(negedge clk);
      check("int_before_clear", {31'd0, INT}, 32'd1);
      @(negedge clk);
      check("int_cleared", {31'd0, INT}, 32'd0);
      rd_reg("pitch_lo_final", 7'h22, mdl(7'h22));

      // Reset in the middle of a write to CTRL1, with the frame still running after release.
      wr_reg("wr_reenable_miso", 7'h0D, 8'h02);
      repeat (150) @(negedge clk);
      check("int_before_reset", {31'd0, INT}, 32'd1);
      xfer(16'h1077, 5, 1'b0, ptch_src, roll_src, yaw_src, junk);
      rst = 1'b1;
      @(negedge clk);
      check("miso_in_reset", {31'd0, MISO}, 32'd0);
      check("int_in_reset", {31'd0, INT}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 5; i < 16; i++) begin
         SCLK = 1'b1;
         repeat (16) @(negedge clk);
         SCLK = 1'b0;
         if (i < 15) MOSI = 1'b0;
         repeat (16) @(negedge clk);
      end
      SS_n = 1'b1;
      m_int1 = 8'h00; m_ctrl1 = 8'h00; m_ctrl2 = 8'h00;
      m_p = 16'h0; m_r = 16'h0; m_y = 16'h0;
      rd_reg("ctrl1_after_reset", 7'h10, mdl(7'h10));
      rd_reg("who_after_reset", 7'h0F, 8'h6A);
      rd_reg("int1_after_reset", 7'h0D, mdl(7'h0D));
      rd_reg("pitch_after_reset", 7'h22, mdl(7'h22));
      check("int_after_reset", {31'd0, INT}, 32'd0);
      repeat (4) @(negedge clk);
      check("miso_idle", {31'd0, MISO}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
